// File: rtl/conv_seq_pkg.sv
// Shared types, constants and output saturation for the convolution frame sequencer.
// Define ABS_MAG_EN to map negative results to their magnitude instead of clamping them to zero.
package conv_seq_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_e;

  localparam int IMG_W_DEF = 130;
  localparam int IMG_H_DEF = 130;
  localparam int RESULT_W  = 16;
  localparam int PIX_W     = 8;

  localparam logic signed [RESULT_W:0] PIX_MAX = 17'sd255;

  function automatic logic [PIX_W-1:0] sat8(input logic signed [RESULT_W-1:0] v);
    // One extra bit so that negating -32768 cannot overflow.
    logic signed [RESULT_W:0] w;
    w = {v[RESULT_W-1], v};
`ifdef ABS_MAG_EN
    if (w < 0) w = -w;
`else
    if (w < 0) w = '0;
`endif
    if (w > PIX_MAX) return {PIX_W{1'b1}};
    return w[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Fixed-depth 1-bit shift register that aligns a tag with a pipelined datapath.
module conv_tag_pipe #(
  parameter int unsigned DEPTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (reset || clear) sr <= '0;
      else                sr <= din;
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (reset || clear) sr <= '0;
      else                sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Raster-scan frame controller for the 3x3 convolution path: read addressing, window tagging
// and dense result write-back. Build option ABS_MAG_EN selects magnitude output for negatives.
module conv_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = 15,
  parameter int BRAM_LAT = 1,
  parameter int TREE_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              win_en,
  input  logic [15:0]       tree_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned PIPE_LAT = BRAM_LAT + TREE_LAT;
  localparam int unsigned COL_W    = $clog2(IMG_W);
  localparam int unsigned ROW_W    = $clog2(IMG_H);
  localparam int unsigned DRN_W    = $clog2(PIPE_LAT) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_e            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DRN_W-1:0]  drain_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              accept;
  logic              tag_in;
  logic              tag_out;

  assign accept = (state == IDLE) && start;
  // Columns 0/1 are masked so windows wrapping across a row boundary never produce a write.
  assign tag_in = (state == SCAN) && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      win_en    <= 1'b0;
      rd_addr   <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            win_en  <= 1'b1;
            rd_addr <= '0;
            col     <= '0;
            row     <= '0;
          end
        end
        SCAN: begin
          if (rd_addr == LAST_ADDR) begin
            state     <= DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            if (col == COL_W'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRN_W'(PIPE_LAT - 1)) begin
            state  <= FIN;
            win_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  conv_tag_pipe #(
    .DEPTH(PIPE_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .din  (tag_in),
    .dout (tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_cnt  <= '0;
    end else begin
      wr_en <= tag_out;
      if (accept) begin
        wr_cnt <= '0;
      end else if (tag_out) begin
        wr_addr <= wr_cnt;
        wr_data <= sat8($signed(tree_result));
        wr_cnt  <= wr_cnt + 1'b1;
      end
    end
  end

endmodule
